// File: rtl/sdrc_xfr_data_engine.sv
// sdrc_xfr_data_engine: SDRAM DQ-side burst data engine.
// Issues column strobes per burst beat, drives write beats to the
// pins (1-cycle latency), returns reads after the latched CAS
// latency and enforces the read-to-write bus turnaround.
// Ports: cmd_* burst handshake, col_strobe to sequencer, x2a_wr*
// / a2x_wr* write side, sdr_* pins, x2a_rd* read return.
// Option: SDRC_DQM_MASK_EN drives sdr_dqm from a2x_wren_n.
module sdrc_xfr_data_engine #(
  parameter int SDR_DW = 16,
  parameter int SDR_BW = 2,
  parameter int BL_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        cas_latency,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [BL_W-1:0]   cmd_len,
  output logic              col_strobe,
  output logic              x2a_wrstart,
  output logic              x2a_wrnext,
  output logic              x2a_wrlast,
  input  logic [SDR_DW-1:0] a2x_wrdt,
  input  logic [SDR_BW-1:0] a2x_wren_n,
  output logic [SDR_DW-1:0] sdr_dout,
  output logic              sdr_den_n,
  output logic [SDR_BW-1:0] sdr_dqm,
  input  logic [SDR_DW-1:0] sdr_din,
  output logic              x2a_rdstart,
  output logic              x2a_rdok,
  output logic              x2a_rdlast,
  output logic [SDR_DW-1:0] x2a_rddt
);

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST,
    TURN
  } state_t;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
    logic cl3;
  } rd_tag_t;

  state_t          state;
  state_t          state_nxt;
  logic [BL_W-1:0] cnt;
  logic            first_q;
  logic            cl3_q;
  logic            rd_seen;
  logic            accept;
  logic            last_beat;
  logic            pipe_busy;
  logic            wr_hold;
  rd_tag_t         push;
  rd_tag_t         pipe0;
  rd_tag_t         pipe1;
  rd_tag_t         pipe2;
  rd_tag_t         emerge;

  assign last_beat = (cnt == '0);
  assign pipe_busy = pipe0.vld | pipe1.vld | pipe2.vld;
  // A write after any read waits for the drain plus one TURN cycle.
  assign wr_hold   = cmd_valid & cmd_wr & rd_seen;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    col_strobe  = 1'b0;
    x2a_wrnext  = 1'b0;
    x2a_wrstart = 1'b0;
    x2a_wrlast  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = ~wr_hold;
        if (wr_hold) begin
          if (!pipe_busy) state_nxt = TURN;
        end else if (cmd_valid) begin
          state_nxt = cmd_wr ? WR_BURST : RD_BURST;
        end
      end
      WR_BURST: begin
        col_strobe  = 1'b1;
        x2a_wrnext  = 1'b1;
        x2a_wrstart = first_q;
        x2a_wrlast  = last_beat;
        if (last_beat) state_nxt = IDLE;
      end
      RD_BURST: begin
        col_strobe = 1'b1;
        // Chaining a read on the last strobe keeps returns contiguous.
        cmd_ready  = last_beat & ~(cmd_valid & cmd_wr);
        if (last_beat) begin
          state_nxt = (cmd_valid & ~cmd_wr) ? RD_BURST : IDLE;
        end
      end
      TURN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      first_q <= 1'b0;
      cl3_q   <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= cmd_len;
        first_q <= 1'b1;
        cl3_q   <= (cas_latency == 2'd3);
      end else if (col_strobe) begin
        first_q <= 1'b0;
        if (!last_beat) cnt <= cnt - 1'b1;
      end
      if (state == TURN) rd_seen <= 1'b0;
      else if (accept & ~cmd_wr) rd_seen <= 1'b1;
    end
  end

  // Each entry carries its own CL so it leaves at stage CL-1.
  always_comb begin
    push.vld   = (state == RD_BURST);
    push.first = first_q;
    push.last  = last_beat;
    push.cl3   = cl3_q;
    emerge     = pipe2;
    if (pipe1.vld & ~pipe1.cl3) emerge = pipe1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe0 <= '0;
      pipe1 <= '0;
      pipe2 <= '0;
    end else begin
      pipe0     <= push;
      pipe1     <= pipe0;
      pipe2     <= pipe1;
      pipe2.vld <= pipe1.vld & pipe1.cl3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x2a_rdok    <= 1'b0;
      x2a_rdstart <= 1'b0;
      x2a_rdlast  <= 1'b0;
      x2a_rddt    <= '0;
    end else begin
      x2a_rdok    <= emerge.vld;
      x2a_rdstart <= emerge.vld & emerge.first;
      x2a_rdlast  <= emerge.vld & emerge.last;
      if (emerge.vld) x2a_rddt <= sdr_din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdr_den_n <= 1'b1;
      sdr_dout  <= '0;
    end else begin
      sdr_den_n <= ~x2a_wrnext;
      sdr_dout  <= x2a_wrnext ? a2x_wrdt : '0;
    end
  end

`ifdef SDRC_DQM_MASK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdr_dqm <= '0;
    end else begin
      sdr_dqm <= x2a_wrnext ? a2x_wren_n : '0;
    end
  end
`else
  logic unused_wren;
  assign unused_wren = ^a2x_wren_n;
  assign sdr_dqm     = '0;
`endif

endmodule

// File: tb/tb_sdrc_xfr_data_engine.sv
// tb_sdrc_xfr_data_engine: directed bench for the data engine.
// Hand-derived cycle expectations for writes, reads and turnaround.
module tb_sdrc_xfr_data_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cas_latency;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_len;
  logic        col_strobe;
  logic        x2a_wrstart;
  logic        x2a_wrnext;
  logic        x2a_wrlast;
  logic [15:0] a2x_wrdt;
  logic [1:0]  a2x_wren_n;
  logic [15:0] sdr_dout;
  logic        sdr_den_n;
  logic [1:0]  sdr_dqm;
  logic [15:0] sdr_din;
  logic        x2a_rdstart;
  logic        x2a_rdok;
  logic        x2a_rdlast;
  logic [15:0] x2a_rddt;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] wr_data [4];
  logic [15:0] rd_data [4];
  logic [1:0]  exp_dqm;

  always #5 clk = ~clk;

  sdrc_xfr_data_engine dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cas_latency (cas_latency),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_len     (cmd_len),
    .col_strobe  (col_strobe),
    .x2a_wrstart (x2a_wrstart),
    .x2a_wrnext  (x2a_wrnext),
    .x2a_wrlast  (x2a_wrlast),
    .a2x_wrdt    (a2x_wrdt),
    .a2x_wren_n  (a2x_wren_n),
    .sdr_dout    (sdr_dout),
    .sdr_den_n   (sdr_den_n),
    .sdr_dqm     (sdr_dqm),
    .sdr_din     (sdr_din),
    .x2a_rdstart (x2a_rdstart),
    .x2a_rdok    (x2a_rdok),
    .x2a_rdlast  (x2a_rdlast),
    .x2a_rddt    (x2a_rddt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // ncmd reads of 2 beats each; c=0 is the first strobe cycle.
  task automatic rd_stream(input int cl, input int ncmd);
    int nb;
    bit ok;
    nb = 2 * ncmd;
    cas_latency = 2'(cl);
    cmd_valid = 1'b1;
    cmd_wr = 1'b0;
    cmd_len = 8'd1;
    @(negedge clk);
    chk("rd_acc_rdy", 32'(cmd_ready), 32'd1);
    nxt();
    if (ncmd == 1) cas_latency = 2'(5 - cl);
    for (int c = 0; c < nb + cl + 3; c++) begin
      cmd_valid = (ncmd == 2) && (c <= 1);
      sdr_din = (c >= cl && c < cl + nb) ?
                rd_data[c-cl] : 16'hDEAD;
      @(negedge clk);
      ok = (c > cl) && (c <= cl + nb);
      chk("rd_strobe", 32'(col_strobe), 32'(c < nb));
      chk("rd_ok", 32'(x2a_rdok), 32'(ok));
      chk("rd_start", 32'(x2a_rdstart),
          32'(c == cl + 1 || (ncmd == 2 && c == cl + 3)));
      chk("rd_last", 32'(x2a_rdlast),
          32'(c == cl + 2 || (ncmd == 2 && c == cl + 4)));
      chk("rd_den", 32'(sdr_den_n), 32'd1);
      chk("rd_dqm", 32'(sdr_dqm), 32'd0);
      if (ok) chk("rd_data", 32'(x2a_rddt),
                  32'(rd_data[c-cl-1]));
      nxt();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int nbeat;
    int lastat;
`ifdef SDRC_DQM_MASK_EN
    exp_dqm = 2'b10;
`else
    exp_dqm = 2'b00;
`endif
    wr_data[0] = 16'h1111;
    wr_data[1] = 16'h2222;
    wr_data[2] = 16'h3333;
    wr_data[3] = 16'h4444;
    rd_data[0] = 16'hA5A5;
    rd_data[1] = 16'h5A5A;
    rd_data[2] = 16'h0F0F;
    rd_data[3] = 16'hF0F0;
    reset_n = 1'b0;
    cas_latency = 2'd2;
    cmd_valid = 1'b0;
    cmd_wr = 1'b0;
    cmd_len = '0;
    a2x_wrdt = '0;
    a2x_wren_n = '0;
    sdr_din = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_den", 32'(sdr_den_n), 32'd1);
    chk("rst_dout", 32'(sdr_dout), 32'd0);
    chk("rst_dqm", 32'(sdr_dqm), 32'd0);
    chk("rst_rddt", 32'(x2a_rddt), 32'd0);
    chk("rst_rdok", 32'(x2a_rdok), 32'd0);
    chk("rst_wrnext", 32'(x2a_wrnext), 32'd0);
    nxt();
    reset_n = 1'b1;
    nxt();

    // 4-beat write with byte mask
    cmd_valid = 1'b1;
    cmd_wr = 1'b1;
    cmd_len = 8'd3;
    @(negedge clk);
    chk("wr_acc_rdy", 32'(cmd_ready), 32'd1);
    nxt();
    cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      a2x_wrdt = (c < 4) ? wr_data[c] : 16'hBEEF;
      a2x_wren_n = 2'b10;
      @(negedge clk);
      chk("wr_next", 32'(x2a_wrnext), 32'(c < 4));
      chk("wr_start", 32'(x2a_wrstart), 32'(c == 0));
      chk("wr_last", 32'(x2a_wrlast), 32'(c == 3));
      chk("wr_strobe", 32'(col_strobe), 32'(c < 4));
      chk("wr_ready", 32'(cmd_ready), 32'(c >= 4));
      chk("wr_den", 32'(sdr_den_n), 32'(!(c >= 1 && c <= 4)));
      if (c >= 1 && c <= 4) begin
        chk("wr_dout", 32'(sdr_dout), 32'(wr_data[c-1]));
        chk("wr_dqm", 32'(sdr_dqm), 32'(exp_dqm));
      end else begin
        chk("wr_dqm_idle", 32'(sdr_dqm), 32'd0);
      end
      nxt();
    end

    // CL=2 read; CL input changed after accept
    rd_stream(2, 1);
    // back-to-back CL=3 reads
    rd_stream(3, 2);

    // CL=3 single read then a write waiting on turnaround
    cas_latency = 2'd3;
    cmd_valid = 1'b1;
    cmd_wr = 1'b0;
    cmd_len = 8'd0;
    nxt();
    cmd_wr = 1'b1;
    a2x_wrdt = 16'h7E57;
    for (int c = 0; c < 7; c++) begin
      sdr_din = (c == 3) ? 16'hC3C3 : 16'hDEAD;
      @(negedge clk);
      chk("ta_ready", 32'(cmd_ready), 32'(c == 6));
      chk("ta_den", 32'(sdr_den_n), 32'd1);
      chk("ta_rdok", 32'(x2a_rdok), 32'(c == 4));
      if (c == 4) chk("ta_rddt", 32'(x2a_rddt), 32'hC3C3);
      nxt();
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("ta_wrlast", 32'(x2a_wrlast), 32'd1);
    chk("ta_wrstart", 32'(x2a_wrstart), 32'd1);
    nxt();
    @(negedge clk);
    chk("ta_den_lo", 32'(sdr_den_n), 32'd0);
    chk("ta_dout", 32'(sdr_dout), 32'h7E57);
    nxt();

    // maximum length write: 256 beats, no wrap
    cmd_valid = 1'b1;
    cmd_wr = 1'b1;
    cmd_len = 8'hFF;
    nxt();
    cmd_valid = 1'b0;
    nbeat = 0;
    lastat = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (x2a_wrnext) nbeat++;
      if (x2a_wrlast && lastat < 0) lastat = c;
      nxt();
    end
    chk("max_beats", 32'(nbeat), 32'd256);
    chk("max_lastat", 32'(lastat), 32'd255);

    // reset at beat 2 of an 8-beat write
    cmd_valid = 1'b1;
    cmd_wr = 1'b1;
    cmd_len = 8'd7;
    nxt();
    cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      a2x_wrdt = 16'h00A0 + 16'(c);
      nxt();
    end
    @(negedge clk);
    chk("rw_den_lo", 32'(sdr_den_n), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rw_den_async", 32'(sdr_den_n), 32'd1);
    chk("rw_wrnext", 32'(x2a_wrnext), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rw_wrlast", 32'(x2a_wrlast), 32'd0);
    end
    nxt();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rw_ready", 32'(cmd_ready), 32'd1);
    nxt();
    rd_stream(2, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
